fp_sqrt_input_stage: RTL
========================

Name: fp_sqrt_input_stage

Overview:
- Parametrised, buffered front end of the sqrt unit; successor to the single-register input wrapper.
- Accepts split operands (exponent, mantissa, flags, type, sign) from the input interface through a valid/ready handshake into a DEPTH-entry FIFO.
- Pops operands one at a time and iteratively normalises denormals, one bit per cycle. Converts the exponent to an even unbiased value and builds the double-width radicand.
- Presents the result to the sqrt core with a valid/ready handshake, plus a start_sqrt pulse.

Parameters:
- IN_M_SIZE, 53: input mantissa width; hidden bit at MSB, left-aligned for both precisions.
- OUT_M_SIZE, 106: radicand width; must equal 2*IN_M_SIZE.
- EXP_SIZE, 11: input biased exponent width; SP uses the low 8 bits.
- DEPTH, 4: FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand present.
- in_ready  out  1  FIFO can accept.
- in_exp  in  EXP_SIZE  biased exponent.
- in_mantisa  in  IN_M_SIZE  mantissa including hidden bit.
- in_flags  in  3  000 denormal, 001 zero, 010 inf, 011 nan, 100 normal.
- in_type  in  1  0 single, 1 double precision.
- sign  in  1  operand sign, 1 = negative.
- out_valid  out  1  result registers valid.
- out_ready  in  1  sqrt core accepts.
- out_exp  out  EXP_SIZE+1  signed unbiased even exponent.
- out_mantisa  out  OUT_M_SIZE  radicand.
- out_flags  out  3  input encoding, plus 111 = sign error.
- out_type  out  1  passed-through in_type.
- out_sign  out  1  passed-through sign.
- start_sqrt  out  1  one-cycle pulse: run the main module.

Behaviour:
- Reset (async, any state): FIFO empty (pointers and count 0), FSM to IDLE; every output 0 except in_ready=1.
- FIFO:
  - Push on in_valid&in_ready; in_ready = (count != DEPTH).
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same edge leaves count unchanged.
  - No push when full; in_valid while full is held upstream and the data is ignored.
- FSM state IDLE:
  - If count != 0: pop head into work registers (W_exp, W_mant, W_flags, W_type, W_sign) and go to NORM.
  - Otherwise stay in IDLE.
- Work-register exponent: signed EXP_SIZE+2 bits.
  - Normal: E = in_exp - bias, with bias 127 for SP and 1023 for DP.
  - Denormal: E = 1 - bias.
- FSM state NORM:
  - While W_flags is denormal and W_mant[MSB] = 0: shift W_mant left 1 and E = E-1 each cycle.
  - A denormal with an all-zero mantissa is reclassified as zero (flags 001).
  - Go to ALIGN when W_mant[MSB] = 1 or the operand is not denormal. Maximum IN_M_SIZE-1 shift cycles.
- FSM state ALIGN (loads output registers; go to ISSUE next):
  - Special handling applies when flags are zero/inf/nan, or when sign=1 and the operand is not zero or nan:
    - out_flags = W_flags, or 111 for the sign case.
    - out_exp = 0 and out_mantisa = 0.
  - Otherwise out_flags = 100:
    - E even: out_exp = E; out_mantisa = W_mant at bits [OUT_M_SIZE-2 : IN_M_SIZE-1], other bits 0. Radicand lies in [1,2).
    - E odd: out_exp = E-1; out_mantisa = W_mant at bits [OUT_M_SIZE-1 : IN_M_SIZE], other bits 0. Radicand lies in [2,4).
  - out_type and out_sign copied from the work registers.
- FSM state ISSUE:
  - out_valid = 1; hold until out_ready.
  - On the handshake edge: out_valid clears; go to IDLE.
  - start_sqrt is registered: high for exactly the one cycle after the handshake edge, and only when out_flags = 100.
- Output data registers hold their value until the next ALIGN, so they are stable for at least 2 cycles after the handshake.
- Latency (edge t = push into an empty FIFO, idle FSM): NORM from t+1, ALIGN from t+2 + k, out_valid high after edge t+3+k, where k = denormal shift count. Throughput is one operand per 4+k cycles.
- Back-pressure: out_ready low holds ISSUE indefinitely. The FIFO keeps accepting until full, so DEPTH+1 operands can be outstanding.

Test Plan:
- DP 4.0 (exp 0x401, mant 1<<52, flags 100), out_ready=1 -> out_valid 3 cycles after push; out_exp=2; out_mantisa bit104 only; out_flags 100; start_sqrt pulse the cycle after the handshake.
- DP 2.0 (exp 0x400), then SP 2.0 (in_type 0, exp 0x080, mant 1<<52) -> both give out_exp=0 and out_mantisa bit105 only.
- DP denormal (exp 0, mant 1<<50, flags 000) -> 2 NORM shifts; out_valid 5 cycles after push; out_exp=-1024; out_mantisa bit104 only.
- NaN (flags 011), then sign=1 normal 4.0 -> out_flags 011, then 111; out_mantisa=0; no start_sqrt pulse.
- Hold out_ready=0 and push 6 operands back-to-back -> in_ready drops after the 5th accept (1 in ISSUE + 4 in FIFO); release -> 5 results in push order, one start_sqrt each.
- Assert rst during NORM of a denormal with 3 entries queued -> next cycle: out_valid=0, in_ready=1, FIFO empty; a fresh push yields a correct result at the nominal latency.

Source files
------------

// File: rtl/fp_sqrt_input_stage.sv
// ---------------------------------------------------------------------------
// fp_sqrt_input_stage
//
// Buffered front end of the square-root unit. Split floating-point operands
// are queued in a small FIFO, popped one at a time, denormals are normalised
// one bit per cycle, and the exponent is made even so the core always sees
// a radicand in [1,4) together with an even unbiased exponent.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   in_valid      operand present on the input bus
//   in_ready      FIFO has room (high whenever count != DEPTH)
//   in_exp        biased exponent (SP uses the low 8 bits)
//   in_mantisa    mantissa with hidden bit at the MSB, left-aligned
//   in_flags      000 denormal, 001 zero, 010 inf, 011 nan, 100 normal
//   in_type       0 single, 1 double precision
//   sign          operand sign, 1 = negative
//   out_valid     result registers hold an operand for the core
//   out_ready     core accepts the operand
//   out_exp       signed, unbiased, even exponent
//   out_mantisa   double-width radicand
//   out_flags     input encoding, or 111 for a negative operand
//   out_type      precision of the operand
//   out_sign      sign of the operand
//   start_sqrt    one-cycle pulse after a handshake on a normal operand
// ---------------------------------------------------------------------------
module fp_sqrt_input_stage #(
    parameter int IN_M_SIZE  = 53,
    parameter int OUT_M_SIZE = 106,   // must be 2*IN_M_SIZE
    parameter int EXP_SIZE   = 11,
    parameter int DEPTH      = 4      // power of 2, at least 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_SIZE-1:0]   in_exp,
    input  logic [IN_M_SIZE-1:0]  in_mantisa,
    input  logic [2:0]            in_flags,
    input  logic                  in_type,
    input  logic                  sign,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_SIZE:0]     out_exp,
    output logic [OUT_M_SIZE-1:0] out_mantisa,
    output logic [2:0]            out_flags,
    output logic                  out_type,
    output logic                  out_sign,
    output logic                  start_sqrt
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = IN_M_SIZE + EXP_SIZE + 5;
    localparam int WE_W    = EXP_SIZE + 2;

    localparam logic [2:0] FL_DENORM  = 3'b000;
    localparam logic [2:0] FL_ZERO    = 3'b001;
    localparam logic [2:0] FL_INF     = 3'b010;
    localparam logic [2:0] FL_NAN     = 3'b011;
    localparam logic [2:0] FL_NORMAL  = 3'b100;
    localparam logic [2:0] FL_SIGNERR = 3'b111;

    localparam logic signed [WE_W-1:0] BIAS_DP = WE_W'((1 << (EXP_SIZE - 1)) - 1);
    localparam logic signed [WE_W-1:0] BIAS_SP = WE_W'(127);
    localparam logic signed [WE_W-1:0] WE_ONE  = WE_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ALIGN,
        S_ISSUE
    } state_t;

    // FIFO storage and bookkeeping
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_count;

    // Work registers for the operand being prepared
    state_t                  r_state;
    logic signed [WE_W-1:0]  r_wExp;
    logic [IN_M_SIZE-1:0]    r_wMant;
    logic [2:0]              r_wFlags;
    logic                    r_wType;
    logic                    r_wSign;

    // Output registers
    logic                  r_outValid;
    logic [EXP_SIZE:0]     r_outExp;
    logic [OUT_M_SIZE-1:0] r_outMant;
    logic [2:0]            r_outFlags;
    logic                  r_outType;
    logic                  r_outSign;
    logic                  r_startSqrt;

    logic                   w_push;
    logic                   w_pop;
    logic [ENTRY_W-1:0]     w_head;
    logic [IN_M_SIZE-1:0]   w_headMant;
    logic [EXP_SIZE-1:0]    w_headExp;
    logic [2:0]             w_headFlags;
    logic                   w_headType;
    logic                   w_headSign;
    logic signed [WE_W-1:0] w_headBiased;
    logic signed [WE_W-1:0] w_headBias;
    logic signed [WE_W-1:0] w_headUnb;
    logic                   w_isSignErr;
    logic                   w_isSpecial;
    logic [EXP_SIZE:0]      w_expMinusOne;
    logic [OUT_M_SIZE-1:0]  w_evenRad;
    logic [OUT_M_SIZE-1:0]  w_oddRad;

    assign in_ready = (r_count != CNT_W'(DEPTH));
    assign w_push   = in_valid & in_ready;
    assign w_pop    = (r_state == S_IDLE) && (r_count != '0);

    assign w_head      = r_mem[r_rdPtr];
    assign w_headMant  = w_head[IN_M_SIZE-1:0];
    assign w_headExp   = w_head[IN_M_SIZE +: EXP_SIZE];
    assign w_headFlags = w_head[IN_M_SIZE+EXP_SIZE +: 3];
    assign w_headType  = w_head[IN_M_SIZE+EXP_SIZE+3];
    assign w_headSign  = w_head[IN_M_SIZE+EXP_SIZE+4];

    // Unbiased exponent of the FIFO head. Single precision only looks at the
    // low 8 exponent bits; denormals take the minimum normal exponent and
    // lose one more per normalising shift later.
    always_comb begin
        w_headBiased = '0;
        w_headBias   = BIAS_DP;
        w_headUnb    = '0;
        if (w_headType) begin
            w_headBiased = {2'b00, w_headExp};
            w_headBias   = BIAS_DP;
        end else begin
            w_headBiased = {{(EXP_SIZE-6){1'b0}}, w_headExp[7:0]};
            w_headBias   = BIAS_SP;
        end
        if (w_headFlags == FL_DENORM) begin
            w_headUnb = WE_ONE - w_headBias;
        end else begin
            w_headUnb = w_headBiased - w_headBias;
        end
    end

    // A negative operand is an error unless it is a zero or a NaN; that case
    // takes priority over the plain inf/zero/nan pass-through.
    assign w_isSignErr   = r_wSign && (r_wFlags != FL_ZERO) && (r_wFlags != FL_NAN);
    assign w_isSpecial   = (r_wFlags == FL_ZERO) || (r_wFlags == FL_INF) || (r_wFlags == FL_NAN);
    assign w_expMinusOne = r_wExp[EXP_SIZE:0] - {{EXP_SIZE{1'b0}}, 1'b1};
    assign w_evenRad     = {1'b0, r_wMant, {(IN_M_SIZE-1){1'b0}}};
    assign w_oddRad      = {r_wMant, {IN_M_SIZE{1'b0}}};

    // FIFO payload write; the array itself needs no reset because the
    // pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {sign, in_type, in_flags, in_exp, in_mantisa};
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the
    // count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Operand preparation FSM: pop, normalise, align, then hold the result
    // until the core takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wExp      <= '0;
            r_wMant     <= '0;
            r_wFlags    <= '0;
            r_wType     <= 1'b0;
            r_wSign     <= 1'b0;
            r_outValid  <= 1'b0;
            r_outExp    <= '0;
            r_outMant   <= '0;
            r_outFlags  <= '0;
            r_outType   <= 1'b0;
            r_outSign   <= 1'b0;
            r_startSqrt <= 1'b0;
        end else begin
            r_startSqrt <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_wExp   <= w_headUnb;
                        r_wMant  <= w_headMant;
                        r_wFlags <= w_headFlags;
                        r_wType  <= w_headType;
                        r_wSign  <= w_headSign;
                        r_state  <= S_NORM;
                    end
                end

                S_NORM: begin
                    if ((r_wFlags == FL_DENORM) && !r_wMant[IN_M_SIZE-1]) begin
                        // An all-zero denormal would never find a leading one.
                        if (r_wMant == '0) begin
                            r_wFlags <= FL_ZERO;
                            r_state  <= S_ALIGN;
                        end else begin
                            r_wMant <= {r_wMant[IN_M_SIZE-2:0], 1'b0};
                            r_wExp  <= r_wExp - WE_ONE;
                        end
                    end else begin
                        r_state <= S_ALIGN;
                    end
                end

                S_ALIGN: begin
                    r_outType <= r_wType;
                    r_outSign <= r_wSign;
                    if (w_isSignErr || w_isSpecial) begin
                        r_outFlags <= w_isSignErr ? FL_SIGNERR : r_wFlags;
                        r_outExp   <= '0;
                        r_outMant  <= '0;
                    end else begin
                        r_outFlags <= FL_NORMAL;
                        // Odd exponents borrow one into the radicand, moving
                        // it from [1,2) to [2,4).
                        if (!r_wExp[0]) begin
                            r_outExp  <= r_wExp[EXP_SIZE:0];
                            r_outMant <= w_evenRad;
                        end else begin
                            r_outExp  <= w_expMinusOne;
                            r_outMant <= w_oddRad;
                        end
                    end
                    r_outValid <= 1'b1;
                    r_state    <= S_ISSUE;
                end

                S_ISSUE: begin
                    if (out_ready) begin
                        r_outValid  <= 1'b0;
                        r_startSqrt <= (r_outFlags == FL_NORMAL);
                        r_state     <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid   = r_outValid;
    assign out_exp     = r_outExp;
    assign out_mantisa = r_outMant;
    assign out_flags   = r_outFlags;
    assign out_type    = r_outType;
    assign out_sign    = r_outSign;
    assign start_sqrt  = r_startSqrt;

endmodule
